// File: rtl/seq_divider_if.sv
// Start/done handshake bundle for seq_divider.
// The div_by_zero flag is present only when SEQ_DIVIDER_DIVZ_EN is defined.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
`ifdef SEQ_DIVIDER_DIVZ_EN
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder
    );
`endif
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Optional macro SEQ_DIVIDER_DIVZ_EN: early divide-by-zero completion with a div_by_zero flag.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SEQ_DIVIDER_DIVZ_EN
    logic             dz_q, dz_d;
`endif

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] diff_s;
    logic             borrow_s;
    logic [WIDTH:0]   trial_rem_s;
    logic [WIDTH-1:0] trial_quo_s;

    // Single trial subtraction: shift in dividend MSB, subtract divisor, restore on borrow
    always_comb begin
        shifted_s   = {rem_q, dvd_q[WIDTH-1]};
        diff_s      = shifted_s - {2'b00, dvs_q};
        borrow_s    = diff_s[WIDTH+1];
        trial_quo_s = {dvd_q[WIDTH-2:0], ~borrow_s};
        if (borrow_s) begin
            trial_rem_s = shifted_s[WIDTH:0];
        end else begin
            trial_rem_s = diff_s[WIDTH:0];
        end
    end

    // Next-state, datapath and output-register update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
`ifdef SEQ_DIVIDER_DIVZ_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    dvd_d   = bus.dividend;
                    dvs_d   = bus.divisor;
                    rem_d   = {(WIDTH+1){1'b0}};
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = S_RUN;
`ifdef SEQ_DIVIDER_DIVZ_EN
                    // Zero divisor completes on the accepting edge with the fixed result
                    if (bus.divisor == {WIDTH{1'b0}}) begin
                        state_d = S_DONE;
                        quo_d   = {WIDTH{1'b1}};
                        rmd_d   = bus.dividend;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                rem_d = trial_rem_s;
                dvd_d = trial_quo_s;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_DONE;
                    quo_d   = trial_quo_s;
                    rmd_d   = trial_rem_s[WIDTH-1:0];
`ifdef SEQ_DIVIDER_DIVZ_EN
                    dz_d    = 1'b0;
`endif
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            rem_q   <= {(WIDTH+1){1'b0}};
            dvd_q   <= {WIDTH{1'b0}};
            dvs_q   <= {WIDTH{1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            rmd_q   <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_DIVIDER_DIVZ_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SEQ_DIVIDER_DIVZ_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rmd_q;
`ifdef SEQ_DIVIDER_DIVZ_EN
    assign bus.div_by_zero = dz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: 8-bit and 4-bit instances, directed vectors plus sweeps.
module tb_seq_divider;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(8)) if8 ();
    seq_divider_if #(.WIDTH(4)) if4 ();

    seq_divider #(.WIDTH(8)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    seq_divider #(.WIDTH(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        sb8[$];
    exp_t        sb4[$];
    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    logic [31:0] hold_q8 = 32'd0;
    logic [31:0] hold_r8 = 32'd0;
    logic [31:0] hold_q4 = 32'd0;
    logic [31:0] hold_r4 = 32'd0;

    logic [7:0] va [0:8] = '{8'd0, 8'd1, 8'd2, 8'd7, 8'd100, 8'd128, 8'd200, 8'd254, 8'd255};
    logic [7:0] vb [0:9] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd16, 8'd128, 8'd200, 8'd254, 8'd255};

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b, input int w);
        if (b == 32'd0) return (32'd1 << w) - 32'd1;
        else            return a / b;
    endfunction

    function automatic logic [31:0] ref_r(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return a;
        else            return a % b;
    endfunction

    // Monitor for the 8-bit instance
    initial begin
        exp_t e8;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb8.delete();
                hold_q8 = 32'd0;
                hold_r8 = 32'd0;
            end else if (if8.done) begin
                if (sb8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL d8_unexpected_done: got done=1, expected no pending result");
                end else begin
                    e8 = sb8.pop_front();
                    chk("d8_quotient", 32'(if8.quotient), e8.q);
                    chk("d8_remainder", 32'(if8.remainder), e8.r);
                    chk("d8_done_cycle", 32'(cyc), 32'(e8.cyc));
                    chk("d8_busy_in_done", {31'd0, if8.busy}, 32'd0);
`ifdef SEQ_DIVIDER_DIVZ_EN
                    chk("d8_div_by_zero", {31'd0, if8.div_by_zero}, {31'd0, e8.dz});
`endif
                    hold_q8 = e8.q;
                    hold_r8 = e8.r;
                end
            end else begin
                chk("d8_hold_quotient", 32'(if8.quotient), hold_q8);
                chk("d8_hold_remainder", 32'(if8.remainder), hold_r8);
            end
        end
    end

    // Monitor for the 4-bit instance
    initial begin
        exp_t e4;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb4.delete();
                hold_q4 = 32'd0;
                hold_r4 = 32'd0;
            end else if (if4.done) begin
                if (sb4.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL d4_unexpected_done: got done=1, expected no pending result");
                end else begin
                    e4 = sb4.pop_front();
                    chk("d4_quotient", 32'(if4.quotient), e4.q);
                    chk("d4_remainder", 32'(if4.remainder), e4.r);
                    chk("d4_done_cycle", 32'(cyc), 32'(e4.cyc));
`ifdef SEQ_DIVIDER_DIVZ_EN
                    chk("d4_div_by_zero", {31'd0, if4.div_by_zero}, {31'd0, e4.dz});
`endif
                    hold_q4 = e4.q;
                    hold_r4 = e4.r;
                end
            end else begin
                chk("d4_hold_quotient", 32'(if4.quotient), hold_q4);
                chk("d4_hold_remainder", 32'(if4.remainder), hold_r4);
            end
        end
    end

    // Called at a negedge; the start is accepted at the following posedge
    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          input logic [31:0] eq, input logic [31:0] er);
        exp_t e;
        int   n;
        n = 0;
        while (if8.busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL d8_issue_timeout: busy still 1, expected 0 within 200 cycles");
        end
        e.q  = eq;
        e.r  = er;
        e.dz = (b == 8'd0);
`ifdef SEQ_DIVIDER_DIVZ_EN
        e.cyc = (b == 8'd0) ? cyc + 1 : cyc + 1 + 8;
`else
        e.cyc = cyc + 1 + 8;
`endif
        sb8.push_back(e);
        if8.dividend = a;
        if8.divisor  = b;
        if8.start    = 1'b1;
        @(negedge clk);
        if8.start    = 1'b0;
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b,
                          input logic [31:0] eq, input logic [31:0] er);
        exp_t e;
        int   n;
        n = 0;
        while (if4.busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL d4_issue_timeout: busy still 1, expected 0 within 200 cycles");
        end
        e.q  = eq;
        e.r  = er;
        e.dz = (b == 4'd0);
`ifdef SEQ_DIVIDER_DIVZ_EN
        e.cyc = (b == 4'd0) ? cyc + 1 : cyc + 1 + 4;
`else
        e.cyc = cyc + 1 + 4;
`endif
        sb4.push_back(e);
        if4.dividend = a;
        if4.divisor  = b;
        if4.start    = 1'b1;
        @(negedge clk);
        if4.start    = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb8.size() != 0 || sb4.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0/0", sb8.size(), sb4.size());
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_d8_busy"}, {31'd0, if8.busy}, 32'd0);
        chk({tag, "_d8_done"}, {31'd0, if8.done}, 32'd0);
        chk({tag, "_d8_quotient"}, 32'(if8.quotient), 32'd0);
        chk({tag, "_d8_remainder"}, 32'(if8.remainder), 32'd0);
        chk({tag, "_d4_busy"}, {31'd0, if4.busy}, 32'd0);
        chk({tag, "_d4_quotient"}, 32'(if4.quotient), 32'd0);
        chk({tag, "_d4_remainder"}, 32'(if4.remainder), 32'd0);
    endtask

    initial begin
        logic [7:0] a8, b8;
        if8.start = 1'b0; if8.dividend = 8'd0; if8.divisor = 8'd0;
        if4.start = 1'b0; if4.dividend = 4'd0; if4.divisor = 4'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);

        issue8(8'd200, 8'd7, 32'd28, 32'd4);
        issue4(4'd13, 4'd4, 32'd3, 32'd1);
        issue4(4'd5, 4'd9, 32'd0, 32'd5);
        drain();

        // Back-to-back: second start raised while the first result is in DONE
        issue8(8'd255, 8'd1, 32'd255, 32'd0);
        issue8(8'd255, 8'd255, 32'd1, 32'd0);
        drain();

        issue8(8'd100, 8'd0, 32'd255, 32'd100);
        drain();

        // A start pulse during RUN must neither restart nor recapture operands
        issue8(8'd50, 8'd3, 32'd16, 32'd2);
        repeat (2) @(negedge clk);
        if8.dividend = 8'd9;
        if8.divisor  = 8'd2;
        if8.start    = 1'b1;
        @(negedge clk);
        if8.start    = 1'b0;
        drain();

        // Asynchronous reset in the fourth RUN cycle abandons the operation
        issue8(8'd77, 8'd5, 32'd15, 32'd2);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("midrun_reset");
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        issue8(8'd77, 8'd5, 32'd15, 32'd2);
        drain();

        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 10; j++) begin
                issue8(va[i], vb[j], ref_q(32'(va[i]), 32'(vb[j]), 8), ref_r(32'(va[i]), 32'(vb[j])));
            end
        end
        for (int k = 0; k < 150; k++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            issue8(a8, b8, ref_q(32'(a8), 32'(b8), 8), ref_r(32'(a8), 32'(b8)));
        end
        drain();

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue4(4'(a), 4'(b), ref_q(32'(a), 32'(b), 4), ref_r(32'(a), 32'(b)));
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
